fetch_decode_queue: RTL and testbench

- Instruction queue between the fetch stage and the decode stage of the RV32IM pipeline; replaces a plain IF/ID register.
- Captures {pc, pc_plus4, instr} from fetch and presents it to decode under a valid/ready handshake.
- Absorbs decode stalls without dropping fetched words.
- Discards all in-flight entries on a redirect (branch, jump or exception) flush.

---
 rtl/rv32_pkg.sv | 16 +
 rtl/fdq_storage.sv | 27 ++
 rtl/fetch_decode_queue.sv | 109 ++++++++++
 tb/tb_fetch_decode_queue.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 pipeline definitions: datapath width, the canonical NOP,
// and the fetch/decode queue entry layout that decode also consumes.
package rv32_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0,x0,0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] instr;
  } fdq_entry_t;

endpackage

// File: rtl/fdq_storage.sv
// Entry array for the fetch/decode queue: one synchronous write port and
// one asynchronous read port. The array has no reset; the queue control
// logic never presents an unwritten slot as valid.
module fdq_storage
  import rv32_pkg::fdq_entry_t;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  fdq_entry_t       wdata,
  input  logic [PTR_W-1:0] raddr,
  output fdq_entry_t       rdata
);

  fdq_entry_t mem [DEPTH];

  // Capture the fetched word into its slot.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode instruction queue (replaces the IF/ID register).
// Buffers {pc, pc_plus4, instr} words under valid/ready handshakes on both
// sides, absorbs decode stalls and drops everything on a redirect flush.
// Optional macro FDQ_BYPASS_EN: an empty queue forwards the fetch word to
// decode combinationally (zero-cycle latency).
module fetch_decode_queue
  import rv32_pkg::fdq_entry_t;
#(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     DEPTH     = 4,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     f_valid,
  output logic                     f_ready,
  input  logic [XLEN-1:0]          pc_in,
  input  logic [XLEN-1:0]          pc_plus4_in,
  input  logic [XLEN-1:0]          instr_in,
  output logic                     d_valid,
  input  logic                     d_ready,
  output logic [XLEN-1:0]          pc_out,
  output logic [XLEN-1:0]          pc_plus4_out,
  output logic [XLEN-1:0]          instr_out,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count_q;
  logic             empty;
  logic             push;
  logic             pop;
  logic             wr_en;
  logic             byp;
  fdq_entry_t       wr_entry;
  fdq_entry_t       head;

  assign wr_entry = '{pc: pc_in, pc_plus4: pc_plus4_in, instr: instr_in};

  assign empty   = (count_q == '0);
  assign f_ready = (count_q != FULL_CNT);
  assign push    = f_valid & f_ready;
  assign pop     = ~empty & d_ready;
  assign count   = count_q;

`ifdef FDQ_BYPASS_EN
  // A word forwarded straight to a ready decode never touches the array.
  assign byp   = empty & f_valid & ~flush;
  assign wr_en = push & ~(byp & d_ready);
`else
  assign byp   = 1'b0;
  assign wr_en = push;
`endif

  fdq_storage #(
    .DEPTH (DEPTH)
  ) u_storage (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Pointer and occupancy tracking; flush overrides any push/pop this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Decode-side view: head entry, bypassed fetch word, or an idle NOP.
  always_comb begin
    d_valid      = ~empty | byp;
    pc_out       = '0;
    pc_plus4_out = '0;
    instr_out    = NOP_INSTR;
    if (byp) begin
      pc_out       = pc_in;
      pc_plus4_out = pc_plus4_in;
      instr_out    = instr_in;
    end else if (!empty) begin
      pc_out       = head.pc;
      pc_plus4_out = head.pc_plus4;
      instr_out    = head.instr;
    end
  end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Self-checking bench for fetch_decode_queue: directed scenarios followed
// by random traffic, all compared against a queue-based reference model.
module tb_fetch_decode_queue;

  localparam int unsigned DEPTH = 4;
`ifdef FDQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        f_valid = 1'b0;
  logic        f_ready;
  logic [31:0] pc_in = '0;
  logic [31:0] pc_plus4_in = '0;
  logic [31:0] instr_in = '0;
  logic        d_valid;
  logic        d_ready = 1'b0;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4_out;
  logic [31:0] instr_out;
  logic [2:0]  count;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] p4;
    logic [31:0] ins;
  } ent_t;

  ent_t q[$];

  fetch_decode_queue #(
    .XLEN      (32),
    .DEPTH     (DEPTH),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .f_valid      (f_valid),
    .f_ready      (f_ready),
    .pc_in        (pc_in),
    .pc_plus4_in  (pc_plus4_in),
    .instr_in     (instr_in),
    .d_valid      (d_valid),
    .d_ready      (d_ready),
    .pc_out       (pc_out),
    .pc_plus4_out (pc_plus4_out),
    .instr_out    (instr_out),
    .count        (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".d_valid"}, 32'(d_valid), 32'd0);
    chk({tag, ".f_ready"}, 32'(f_ready), 32'd1);
    chk({tag, ".pc_out"}, pc_out, 32'd0);
    chk({tag, ".pc_plus4_out"}, pc_plus4_out, 32'd0);
    chk({tag, ".instr_out"}, instr_out, 32'h13);
    chk({tag, ".count"}, 32'(count), 32'd0);
  endtask

  // One clock cycle: drive at negedge, check outputs against the model,
  // then advance the model across the rising edge.
  task automatic step(input string tag, input logic fv, input logic [31:0] pc,
                      input logic [31:0] p4, input logic [31:0] ins,
                      input logic dr, input logic fl);
    ent_t e;
    bit   byp, dv, fr, pop, push;
    @(negedge clk);
    f_valid = fv; pc_in = pc; pc_plus4_in = p4; instr_in = ins;
    d_ready = dr; flush = fl;
    #1;
    fr  = (q.size() != DEPTH);
    byp = BYP && (q.size() == 0) && fv && !fl;
    dv  = (q.size() != 0) || byp;
    if (byp)              e = '{pc, p4, ins};
    else if (q.size() != 0) e = q[0];
    else                  e = '{32'd0, 32'd0, 32'h13};
    chk({tag, ".d_valid"}, 32'(d_valid), 32'(dv));
    chk({tag, ".f_ready"}, 32'(f_ready), 32'(fr));
    chk({tag, ".count"}, 32'(count), q.size());
    chk({tag, ".pc_out"}, pc_out, e.pc);
    chk({tag, ".pc_plus4_out"}, pc_plus4_out, e.p4);
    chk({tag, ".instr_out"}, instr_out, e.ins);
    pop  = (q.size() != 0) && dr;
    push = fv && fr;
    @(posedge clk);
    if (fl) q.delete();
    else if (!(byp && dr)) begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back('{pc, p4, ins});
    end
  endtask

  task automatic push_word(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                           input logic dr);
    step(tag, 1'b1, pc, pc + 32'd4, ins, dr, 1'b0);
  endtask

  task automatic idle(input string tag, input logic dr);
    step(tag, 1'b0, 32'd0, 32'd0, 32'd0, dr, 1'b0);
  endtask

  initial begin
    // Reset then idle.
    #8;
    chk_idle("reset");
    rst = 1'b0;
    #2;
    chk_idle("post_reset");

    // Streaming with decode always ready.
    push_word("stream0", 32'h0, 32'hA, 1'b1);
    push_word("stream1", 32'h4, 32'hB, 1'b1);
    push_word("stream2", 32'h8, 32'hC, 1'b1);
    idle("stream_tail", 1'b1);
    idle("stream_idle", 1'b1);

    // Back-pressure: fill, hold the 5th word, then drain in order.
    push_word("bp0", 32'h0, 32'hA, 1'b0);
    push_word("bp1", 32'h4, 32'hB, 1'b0);
    push_word("bp2", 32'h8, 32'hC, 1'b0);
    push_word("bp3", 32'hC, 32'hD, 1'b0);
    push_word("bp_full_hold", 32'h10, 32'hE, 1'b0);
    push_word("bp_pop_full", 32'h10, 32'hE, 1'b1);
    push_word("bp_accept5", 32'h10, 32'hE, 1'b1);
    for (int i = 0; i < 5; i++) idle("bp_drain", 1'b1);

    // Wrap-around at steady occupancy of 2.
    push_word("wrap_fill0", 32'h20, 32'h1000, 1'b0);
    push_word("wrap_fill1", 32'h24, 32'h1001, 1'b0);
    for (int i = 0; i < 10; i++)
      push_word("wrap_pair", 32'h28 + 32'(i) * 4, 32'h2000 + 32'(i), 1'b1);
    idle("wrap_drain0", 1'b1);
    idle("wrap_drain1", 1'b1);
    idle("wrap_empty", 1'b1);

    // Flush together with a push.
    push_word("fl_fill0", 32'h40, 32'h40, 1'b0);
    push_word("fl_fill1", 32'h44, 32'h44, 1'b0);
    push_word("fl_fill2", 32'h48, 32'h48, 1'b0);
    step("fl_push", 1'b1, 32'h100, 32'h104, 32'h100, 1'b0, 1'b1);
    push_word("fl_after", 32'h200, 32'h200, 1'b0);
    idle("fl_head", 1'b1);
    idle("fl_empty", 1'b1);

    // Async reset between clock edges.
    push_word("ar_fill0", 32'h60, 32'h60, 1'b0);
    push_word("ar_fill1", 32'h64, 32'h64, 1'b0);
    push_word("ar_fill2", 32'h68, 32'h68, 1'b0);
    @(negedge clk);
    f_valid = 1'b0; d_ready = 1'b0; flush = 1'b0;
    #1;
    chk("ar_pre.count", 32'(count), 32'd3);
    #1;
    rst = 1'b1;
    #1;
    chk_idle("async_reset");
    q.delete();
    #1;
    rst = 1'b0;
    idle("ar_after", 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0));
    end
    for (int i = 0; i < 6; i++) idle("rand_drain", 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
